alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one combinational bitwise ALU datapath (NOT/AND/OR/XOR slice, built from the parameterized gate modules) between two requesters. Each requester issues an operation with a valid/ready handshake; the arbiter grants round-robin, drives the shared ALU from registered operands, captures the result and returns it to the winner with a valid/ready response. It sits between the CPU front-end ports and the single ALU instance.

## Interface
- WIDTH, 4, operand/result width in bits
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- r0_req_valid  input  1  requester 0 has an operation
- r0_req_ready  output  1  requester 0 operation accepted this cycle
- r0_req_op  input  2  00 NOT a, 01 AND, 10 OR, 11 XOR
- r0_req_a, r0_req_b  input  WIDTH  operands (b ignored for NOT)
- r0_resp_valid  output  1  result for requester 0 available
- r0_resp_ready  input  1  requester 0 consumes result
- r0_resp_data  output  WIDTH  result
- r1_*  same set as r0_* for requester 1
- alu_op  output  2  op to shared ALU
- alu_a, alu_b  output  WIDTH  operands to shared ALU
- alu_result  input  WIDTH  combinational result from shared ALU
- resp_zero  output  1  result is all-zero (only with ALU_ARB_ZERO_FLAG_EN)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, pick winner: if both valid, the requester indicated by priority pointer `prio` (0 or 1); else the sole valid one. Winner's req_ready high combinationally in this cycle; loser's low. On handshake: latch op/a/b, owner id → EXEC; prio ← !owner.
- IDLE with no valid: stay, both req_ready low, prio unchanged.
- EXEC: alu_op/alu_a/alu_b driven from latched registers; alu_result captured into result register at cycle end → RESP.
- RESP: owner's resp_valid high, resp_data = captured result; other requester's resp_valid low, its resp_data 0. Result held stable until owner's resp_ready high → IDLE.
- req_ready is low for both requesters in EXEC and RESP; new requests wait.
- alu_* outputs hold last latched values outside EXEC (no toggling when idle).
- Reset mid-operation: immediate return to IDLE; in-flight operation discarded, no response issued.
- Width: all data WIDTH bits, no carry/overflow; NOT ignores b.

## Timing
- Reset values: state IDLE, prio 0, owner 0, r0/r1_req_ready 0 (combinational, low since no valid can be granted only via IDLE logic — ready follows valid in IDLE after reset), r0/r1_resp_valid 0, r0/r1_resp_data 0, alu_op 0, alu_a 0, alu_b 0, resp_zero 0.
- Handshake in cycle N → EXEC in N+1 → resp_valid high from N+2.
- resp_ready high in the first RESP cycle → IDLE at N+3; next grant possible in N+3; maximum throughput one op per 3 cycles.
- resp_ready sampled only for the owner; the non-owner's resp_ready is ignored.
- Simultaneous valid from both in IDLE: prio decides; alternation guaranteed under continuous contention.
- req_valid dropped before handshake: no state change.

## Configuration
- ALU_ARB_ZERO_FLAG_EN defined: resp_zero port present; registered alongside result in EXEC, equals (alu_result == 0), valid only while either resp_valid high, 0 otherwise and at reset.
- Not defined: resp_zero port and its register absent; all other behaviour identical.

## Test plan
- Reset: assert rst mid-EXEC of r0 XOR 4'hF,4'h3 → all outputs 0, state IDLE, no response after release.
- Single: r0 NOT a=4'b0101 → r0_req_ready in N, alu_op=00/alu_a=5 in N+1, r0_resp_valid with data 4'b1010 in N+2.
- Contention: both valid continuously, r0 AND 4'hC,4'hA, r1 OR 4'h1,4'h2 → grants r0, r1, r0, r1; results 4'h8 and 4'h3 to correct owners.
- Backpressure: r1 XOR 4'h6,4'h5 with r1_resp_ready low 5 cycles → resp_valid and data 4'h3 held stable, r0 request not granted until release.
- Non-owner ready: r0 owns RESP, r1_resp_ready high, r0_resp_ready low → stays in RESP.
- Zero flag (macro on): r0 AND 4'hA,4'h5 → data 4'h0, resp_zero 1; r0 OR 4'hA,4'h5 → 4'hF, resp_zero 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one bitwise ALU between two requesters.
// Optional ALU_ARB_ZERO_FLAG_EN adds a registered resp_zero flag.
//
// state | meaning
// IDLE  | waiting for a request; grants the winner combinationally
// EXEC  | latched operands drive the ALU; result captured at cycle end
// RESP  | result presented to the owner until it asserts resp_ready
module alu_share_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r0_req_valid,
   output logic             r0_req_ready,
   input  logic [1:0]       r0_req_op,
   input  logic [WIDTH-1:0] r0_req_a,
   input  logic [WIDTH-1:0] r0_req_b,
   output logic             r0_resp_valid,
   input  logic             r0_resp_ready,
   output logic [WIDTH-1:0] r0_resp_data,
   input  logic             r1_req_valid,
   output logic             r1_req_ready,
   input  logic [1:0]       r1_req_op,
   input  logic [WIDTH-1:0] r1_req_a,
   input  logic [WIDTH-1:0] r1_req_b,
   output logic             r1_resp_valid,
   input  logic             r1_resp_ready,
   output logic [WIDTH-1:0] r1_resp_data,
   output logic [1:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
`ifdef ALU_ARB_ZERO_FLAG_EN
   output logic             resp_zero,
`endif
   input  logic [WIDTH-1:0] alu_result
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             prio_q, owner_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, result_q;
   logic             grant0, grant1, owner_ready, handshake;

   // prio_q == 0 favours requester 0 when both are valid
   assign grant0      = r0_req_valid && (!r1_req_valid || !prio_q);
   assign grant1      = r1_req_valid && (!r0_req_valid || prio_q);
   assign owner_ready = owner_q ? r1_resp_ready : r0_resp_ready;
   assign handshake   = r0_req_ready || r1_req_ready;

   always_comb begin
      state_d      = state_q;
      r0_req_ready = 1'b0;
      r1_req_ready = 1'b0;
      case (state_q)
         IDLE: begin
            r0_req_ready = grant0;
            r1_req_ready = grant1;
            if (grant0 || grant1) state_d = EXEC;
         end
         EXEC:    state_d = RESP;
         RESP:    if (owner_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         owner_q  <= 1'b0;
         op_q     <= 2'b00;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (handshake) begin
            owner_q <= r1_req_ready;
            prio_q  <= !r1_req_ready;
            op_q    <= r1_req_ready ? r1_req_op : r0_req_op;
            a_q     <= r1_req_ready ? r1_req_a  : r0_req_a;
            b_q     <= r1_req_ready ? r1_req_b  : r0_req_b;
         end
         if (state_q == EXEC) result_q <= alu_result;
      end
   end

   // Operand registers only change on a handshake, so the ALU inputs stay quiet when idle
   assign alu_op = op_q;
   assign alu_a  = a_q;
   assign alu_b  = b_q;

   assign r0_resp_valid = (state_q == RESP) && !owner_q;
   assign r1_resp_valid = (state_q == RESP) &&  owner_q;
   assign r0_resp_data  = r0_resp_valid ? result_q : '0;
   assign r1_resp_data  = r1_resp_valid ? result_q : '0;

`ifdef ALU_ARB_ZERO_FLAG_EN
   logic zero_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
      end else if (state_q == EXEC) begin
         zero_q <= (alu_result == '0);
      end
   end

   assign resp_zero = zero_q && (r0_resp_valid || r1_resp_valid);
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random traffic
// against a transaction-level model. Honors ALU_ARB_ZERO_FLAG_EN when defined.
module tb_alu_share_arbiter;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
   logic [1:0]   op0 = 0, op1 = 0;
   logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic         r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid;
   logic [W-1:0] r0_resp_data, r1_resp_data, alu_a, alu_b, alu_result;
   logic [1:0]   alu_op;
   logic         zero_obs;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .r0_req_valid(v0), .r0_req_ready(r0_req_ready), .r0_req_op(op0),
      .r0_req_a(a0), .r0_req_b(b0), .r0_resp_valid(r0_resp_valid),
      .r0_resp_ready(rr0), .r0_resp_data(r0_resp_data),
      .r1_req_valid(v1), .r1_req_ready(r1_req_ready), .r1_req_op(op1),
      .r1_req_a(a1), .r1_req_b(b1), .r1_resp_valid(r1_resp_valid),
      .r1_resp_ready(rr1), .r1_resp_data(r1_resp_data),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
`ifdef ALU_ARB_ZERO_FLAG_EN
      .resp_zero(zero_obs),
`endif
      .alu_result(alu_result)
   );
`ifndef ALU_ARB_ZERO_FLAG_EN
   assign zero_obs = 1'b0;
`endif

   function automatic logic [W-1:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         2'b00:   return ~a;
         2'b01:   return a & b;
         2'b10:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // External shared ALU
   always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

   // Transaction-level model: a job is accepted, is busy for "age" cycles, and
   // its result is offered from the second cycle after acceptance until consumed.
   logic         m_busy, m_prio, m_owner;
   int           m_age;
   logic [1:0]   m_op;
   logic [W-1:0] m_a, m_b, m_res;
   logic         e_g0, e_g1, e_rv0, e_rv1;
   logic [22:0]  exp_vec, obs_vec;

   always_comb begin
      e_g0  = !m_busy && v0 && (!v1 || !m_prio);
      e_g1  = !m_busy && v1 && (!v0 ||  m_prio);
      e_rv0 = m_busy && (m_age >= 2) && !m_owner;
      e_rv1 = m_busy && (m_age >= 2) &&  m_owner;
      exp_vec = {1'b0, e_g0, e_g1, e_rv0, e_rv1,
                 e_rv0 ? m_res : 4'h0, e_rv1 ? m_res : 4'h0, m_op, m_a, m_b};
`ifdef ALU_ARB_ZERO_FLAG_EN
      exp_vec[22] = (e_rv0 || e_rv1) && (m_res == 4'h0);
`endif
   end

   assign obs_vec = {zero_obs, r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid,
                     r0_resp_data, r1_resp_data, alu_op, alu_a, alu_b};

   task automatic model_reset();
      m_busy = 0; m_prio = 0; m_owner = 0; m_age = 0;
      m_op = 0; m_a = 0; m_b = 0; m_res = 0;
   endtask

   // Update the model with the inputs of this cycle, then move to the next negedge.
   task automatic advance();
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         if (e_g0 || e_g1) begin
            m_owner = e_g1;
            m_op    = e_g1 ? op1 : op0;
            m_a     = e_g1 ? a1  : a0;
            m_b     = e_g1 ? b1  : b0;
            m_res   = alu_fn(m_op, m_a, m_b);
            m_busy  = 1; m_age = 1;
            m_prio  = !m_owner;
         end
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (m_owner ? rr1 : rr0) begin
         m_busy = 0;
      end
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      advance();
      rst = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      model_reset();
      #1;
      n_checks++;
      if (obs_vec !== 23'h0) $display("FAIL reset_vals got=%h want=%h", obs_vec, 23'h0);
      else n_pass++;
      advance();
      rst = 0;
      v0 = 1; op0 = 2'b11; a0 = 4'hF; b0 = 4'h3;
      #1;
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL reset_grant got=%h want=%h", obs_vec, exp_vec);
      else n_pass++;
      advance();
      v0 = 0;
      #1;
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL reset_exec got=%h want=%h", obs_vec, exp_vec);
      else n_pass++;
      rst = 1;
      #1;
      model_reset();
      n_checks++;
      if (obs_vec !== 23'h0) $display("FAIL reset_midexec got=%h want=%h", obs_vec, 23'h0);
      else n_pass++;
      advance();
      rst = 0;
      rr0 = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (obs_vec !== exp_vec || r0_resp_valid !== 1'b0)
            $display("FAIL reset_noresp got=%h want=%h", obs_vec, exp_vec);
         else n_pass++;
         advance();
      end
      clear_inputs();
   endtask

   task automatic test_single();
      v0 = 1; op0 = 2'b00; a0 = 4'b0101; b0 = 4'hE; rr0 = 0;
      #1;
      n_checks++;
      if (r0_req_ready !== 1'b1 || obs_vec !== exp_vec)
         $display("FAIL single_ready got=%b want=1", r0_req_ready);
      else n_pass++;
      advance();
      v0 = 0;
      #1;
      n_checks++;
      if (alu_op !== 2'b00 || alu_a !== 4'h5) $display("FAIL single_alu got=%h/%h want=0/5", alu_op, alu_a);
      else n_pass++;
      advance();
      rr0 = 1;
      #1;
      n_checks++;
      if (r0_resp_valid !== 1'b1 || r0_resp_data !== 4'b1010)
         $display("FAIL single_resp got=%b/%h want=1/a", r0_resp_valid, r0_resp_data);
      else n_pass++;
      advance();
      #1;
      n_checks++;
      if (obs_vec !== exp_vec || r0_resp_valid !== 1'b0)
         $display("FAIL single_idle got=%h want=%h", obs_vec, exp_vec);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_contention();
      int grants[$];
      do_reset();
      v0 = 1; op0 = 2'b01; a0 = 4'hC; b0 = 4'hA;
      v1 = 1; op1 = 2'b10; a1 = 4'h1; b1 = 4'h2;
      rr0 = 1; rr1 = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         n_checks++;
         if (obs_vec !== exp_vec) $display("FAIL contention_cyc%0d got=%h want=%h", i, obs_vec, exp_vec);
         else n_pass++;
         if (r0_req_ready) grants.push_back(0);
         if (r1_req_ready) grants.push_back(1);
         if (r0_resp_valid || r1_resp_valid) begin
            n_checks++;
            if ((r0_resp_valid && r0_resp_data !== 4'h8) || (r1_resp_valid && r1_resp_data !== 4'h3))
               $display("FAIL contention_data got=%h/%h want=8/3", r0_resp_data, r1_resp_data);
            else n_pass++;
         end
         advance();
      end
      n_checks++;
      if (grants.size() != 4) $display("FAIL contention_count got=%0d want=4", grants.size());
      else n_pass++;
      for (int i = 0; i < grants.size(); i++) begin
         n_checks++;
         if (grants[i] != i % 2) $display("FAIL contention_order%0d got=%0d want=%0d", i, grants[i], i % 2);
         else n_pass++;
      end
      clear_inputs();
      advance();
   endtask

   task automatic test_backpressure();
      do_reset();
      v1 = 1; op1 = 2'b11; a1 = 4'h6; b1 = 4'h5; rr1 = 0;
      #1;
      n_checks++;
      if (r1_req_ready !== 1'b1) $display("FAIL bp_grant got=%b want=1", r1_req_ready);
      else n_pass++;
      advance();
      v1 = 0; v0 = 1; op0 = 2'b10; a0 = 4'h9; b0 = 4'h4;
      advance();
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (r1_resp_valid !== 1'b1 || r1_resp_data !== 4'h3 || r0_req_ready !== 1'b0 || obs_vec !== exp_vec)
            $display("FAIL bp_hold%0d got=%b/%h/%b want=1/3/0", i, r1_resp_valid, r1_resp_data, r0_req_ready);
         else n_pass++;
         advance();
      end
      rr1 = 1;
      advance();
      #1;
      n_checks++;
      if (r0_req_ready !== 1'b1 || obs_vec !== exp_vec) $display("FAIL bp_release got=%b want=1", r0_req_ready);
      else n_pass++;
      advance();
      v0 = 0; rr0 = 1;
      advance();
      advance();
      clear_inputs();
   endtask

   task automatic test_non_owner();
      do_reset();
      v0 = 1; op0 = 2'b01; a0 = 4'h7; b0 = 4'h3; rr0 = 0; rr1 = 1;
      advance();
      v0 = 0;
      advance();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (r0_resp_valid !== 1'b1 || r1_resp_valid !== 1'b0 || r1_resp_data !== 4'h0 || r0_resp_data !== 4'h3)
            $display("FAIL nonowner%0d got=%b/%b/%h want=1/0/3", i, r0_resp_valid, r1_resp_valid, r0_resp_data);
         else n_pass++;
         advance();
      end
      rr0 = 1;
      advance();
      #1;
      n_checks++;
      if (r0_resp_valid !== 1'b0 || obs_vec !== exp_vec) $display("FAIL nonowner_done got=%h want=%h", obs_vec, exp_vec);
      else n_pass++;
      clear_inputs();
   endtask

`ifdef ALU_ARB_ZERO_FLAG_EN
   task automatic test_zero_flag();
      logic [3:0] want_d [2];
      logic       want_z [2];
      want_d[0] = 4'h0; want_z[0] = 1'b1;
      want_d[1] = 4'hF; want_z[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         v0 = 1; op0 = (k == 0) ? 2'b01 : 2'b10; a0 = 4'hA; b0 = 4'h5; rr0 = 1;
         advance();
         v0 = 0;
         #1;
         n_checks++;
         if (zero_obs !== 1'b0) $display("FAIL zero_exec%0d got=%b want=0", k, zero_obs);
         else n_pass++;
         advance();
         #1;
         n_checks++;
         if (r0_resp_data !== want_d[k] || zero_obs !== want_z[k])
            $display("FAIL zero_flag%0d got=%h/%b want=%h/%b", k, r0_resp_data, zero_obs, want_d[k], want_z[k]);
         else n_pass++;
         advance();
      end
      clear_inputs();
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         v0 = ($urandom_range(0, 3) != 0); op0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
         v1 = ($urandom_range(0, 3) != 0); op1 = 2'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
         rr0 = ($urandom_range(0, 2) != 0); rr1 = ($urandom_range(0, 2) != 0);
         #1;
         n_checks++;
         if (obs_vec !== exp_vec) $display("FAIL random_cyc%0d got=%h want=%h", i, obs_vec, exp_vec);
         else n_pass++;
         advance();
      end
      clear_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_non_owner();
`ifdef ALU_ARB_ZERO_FLAG_EN
      test_zero_flag();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
